cond_evaluator: RTL

// - Consumer side of the adder's result/flag interface: holds the V/N/Z/C status register written by adder ops.
// - Answers condition-code queries (ARM-style 4-bit codes) against those flags through a valid/ready pipeline stage.
// - Sits between the ALU/adder and branch/predication control. One result per accepted query, 1-cycle latency.

---
 rtl/cond_pkg.sv | 35 +++
 rtl/cond_decode.sv | 46 ++++
 rtl/cond_evaluator.sv | 87 ++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for condition-code evaluation: flag bit positions,
// ARM-style condition codes and the output-stage state type.
package cond_pkg;

    // Bit positions inside the 4-bit status word {C,Z,N,V}
    localparam int FLAG_V = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 3;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Output stage occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/cond_decode.sv
// Purely combinational condition evaluator: (flags, code) -> pass.
// Shared with the branch unit, so it carries no state.
module cond_decode
    import cond_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] code,
    output logic       pass
);

    logic flag_v;
    logic flag_n;
    logic flag_z;
    logic flag_c;

    assign flag_v = flags[FLAG_V];
    assign flag_n = flags[FLAG_N];
    assign flag_z = flags[FLAG_Z];
    assign flag_c = flags[FLAG_C];

    // Evaluate the selected condition against the supplied flags
    always_comb begin
        // NOTE: default assignment first so no path leaves pass unassigned (no latch).
        pass = 1'b0;
        case (code)
            COND_EQ: pass = flag_z;
            COND_NE: pass = !flag_z;
            COND_CS: pass = flag_c;
            COND_CC: pass = !flag_c;
            COND_MI: pass = flag_n;
            COND_PL: pass = !flag_n;
            COND_VS: pass = flag_v;
            COND_VC: pass = !flag_v;
            COND_HI: pass = flag_c && !flag_z;
            COND_LS: pass = !flag_c || flag_z;
            COND_GE: pass = (flag_n == flag_v);
            COND_LT: pass = (flag_n != flag_v);
            COND_GT: pass = !flag_z && (flag_n == flag_v);
            COND_LE: pass = flag_z || (flag_n != flag_v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_evaluator.sv
// Status register plus a one-deep valid/ready result stage answering
// condition-code queries. A query accepted together with a flag write sees
// the new flags; a stalled query is evaluated only when it is accepted.
module cond_evaluator
    import cond_pkg::*;
#(
    parameter int         TAG_W       = 4,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flag_wr,
    input  logic [3:0]       flags_in,
    input  logic             cond_valid,
    output logic             cond_ready,
    input  logic [3:0]       cond_code,
    input  logic [TAG_W-1:0] cond_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_pass,
    output logic [TAG_W-1:0] res_tag,
    output logic [3:0]       flags_q
);

    out_state_e state_q;
    out_state_e state_d;
    logic [3:0] eval_flags;
    logic       eval_pass;
    logic       accept;

    // Forward a same-cycle flag write to the query being accepted
    assign eval_flags = flag_wr ? flags_in : flags_q;
    assign accept     = cond_valid && cond_ready;

    cond_decode u_decode (
        .flags (eval_flags),
        .code  (cond_code),
        .pass  (eval_pass)
    );

    // Status register: written only by the adder's flag write
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking assignments in clocked blocks keep all registers updating from pre-edge values.
        if (!reset_n) begin
            flags_q <= RESET_FLAGS;
        end else if (flag_wr) begin
            flags_q <= flags_in;
        end
    end

    // Output-stage state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: fill on accept, drain on consume, refill when both happen
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (res_ready && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Outputs decoded from state; ready passes straight through from res_ready
    always_comb begin
        res_valid  = (state_q == ST_FULL);
        cond_ready = (state_q == ST_EMPTY) || res_ready;
    end

    // Result payload loads only on accept, so it holds while stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_pass <= 1'b0;
            res_tag  <= '0;
        end else if (accept) begin
            res_pass <= eval_pass;
            res_tag  <= cond_tag;
        end
    end

endmodule
